// File: rtl/stim_pkg.sv
// stim_pkg: shared mode/state encodings and constants for the pulse generator
package stim_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, PERIODIC = 2'd1, ONESHOT = 2'd2, BURST = 2'd3} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_e;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/stim_pulse_channel.sv
// stim_pulse_channel: one pulse channel with shadow/active config, clamping and phase FSM
module stim_pulse_channel
  import stim_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int WID_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               cfg_we,
  input  mode_e              cfg_mode,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [WID_W-1:0]   cfg_width,
  input  logic [BURST_W-1:0] cfg_count,
  input  logic               start,
  input  logic               stop,
  output logic               pulse_out,
  output logic               busy,
  output logic               done
);
  mode_e sh_mode, mode;
  state_e state, state_n;
  logic [CNT_W-1:0] sh_period, period, width, cp, wz, cw, cnt, cnt_n;
  logic [WID_W-1:0] sh_width;
  logic [BURST_W-1:0] sh_count, cc, rem, rem_n;
  logic ld;
  // Shadow config, written at any time, only consumed at load points
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sh_mode   <= OFF;
      sh_period <= CNT_W'(2);
      sh_width  <= WID_W'(1);
      sh_count  <= BURST_W'(1);
    end else if (cfg_we) begin
      sh_mode   <= cfg_mode;
      sh_period <= cfg_period;
      sh_width  <= cfg_width;
      sh_count  <= cfg_count;
    end
  end
  // Clamp shadow values so the width and low-phase counters can never wrap
  always_comb begin
    cp = (sh_period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : sh_period;
    wz = (sh_width == '0) ? CNT_W'(1) : CNT_W'(sh_width);
    cw = (wz >= cp) ? cp - CNT_W'(1) : wz;
    cc = (sh_count == '0) ? BURST_W'(1) : sh_count;
  end
  // Next-state: counters reload on phase entry, config reloads on each new pulse
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    ld      = 1'b0;
    if (stop) state_n = IDLE;
    else if (state == IDLE) begin
      if (start && !pulse_out && sh_mode != OFF) begin
        state_n = HIGH;
        ld      = 1'b1;
        cnt_n   = cw - CNT_W'(1);
        rem_n   = cc;
      end
    end else if (cnt != '0) cnt_n = cnt - CNT_W'(1);
    else if (state == HIGH) begin
      if (mode == ONESHOT || (mode == BURST && rem == BURST_W'(1))) state_n = IDLE;
      else begin
        state_n = LOW;
        cnt_n   = period - width - CNT_W'(1);
        rem_n   = rem - BURST_W'(1);
      end
    end else if (sh_mode == OFF) state_n = IDLE;
    else begin
      state_n = HIGH;
      ld      = 1'b1;
      cnt_n   = cw - CNT_W'(1);
      rem_n   = (mode == BURST) ? rem : cc;
    end
  end
  // State, active config and registered outputs
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= BURST_W'(1);
      mode      <= OFF;
      period    <= CNT_W'(2);
      width     <= CNT_W'(1);
      pulse_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rem       <= rem_n;
      mode      <= ld ? sh_mode : mode;
      period    <= ld ? cp : period;
      width     <= ld ? cw : width;
      pulse_out <= state == HIGH && !stop;
      done      <= state == IDLE && pulse_out && !stop;
    end
  end
  assign busy = state != IDLE || pulse_out;
endmodule

// File: rtl/stim_pulse_gen.sv
// stim_pulse_gen: multi-channel programmable periodic/one-shot/burst pulse generator
module stim_pulse_gen
  import stim_pkg::*;
#(
  parameter int  CHANNELS = 2,
  parameter int  CNT_W    = 16,
  parameter int  WID_W    = 8,
  parameter int  BURST_W  = 8,
  localparam int CH_W     = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [WID_W-1:0]    cfg_width,
  input  logic [BURST_W-1:0]  cfg_count,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    stim_pulse_channel #(.CNT_W(CNT_W), .WID_W(WID_W), .BURST_W(BURST_W)) u_ch (
      .sysclk    (sysclk),
      .rst       (rst),
      .cfg_we    (cfg_we && cfg_ch == CH_W'(c)),
      .cfg_mode  (mode_e'(cfg_mode)),
      .cfg_period(cfg_period),
      .cfg_width (cfg_width),
      .cfg_count (cfg_count),
      .start     (start[c]),
      .stop      (stop[c]),
      .pulse_out (pulse_out[c]),
      .busy      (busy[c]),
      .done      (done[c])
    );
  end
endmodule

// File: tb/tb_stim_pulse_gen.sv
// tb_stim_pulse_gen: directed scenario checks for stim_pulse_gen
module tb_stim_pulse_gen;
  logic sysclk = 1'b0;
  logic rst, cfg_we, cfg_ch;
  logic [1:0] cfg_mode, start, stop;
  logic [15:0] cfg_period;
  logic [7:0] cfg_width, cfg_count;
  logic [1:0] pulse_out, busy, done;
  int errors = 0;
  int checks = 0;
  always #5 sysclk = ~sysclk;
  stim_pulse_gen #(.CHANNELS(2), .CNT_W(16), .WID_W(8), .BURST_W(8)) dut (
    .sysclk(sysclk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_count(cfg_count),
    .start(start), .stop(stop), .pulse_out(pulse_out), .busy(busy), .done(done)
  );
  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask
  task automatic cfg(input logic ch, input logic [1:0] m, input int p, input int w, input int c);
    cfg_ch = ch;
    cfg_mode = m;
    cfg_period = 16'(p);
    cfg_width = 8'(w);
    cfg_count = 8'(c);
    cfg_we = 1'b1;
    tick;
    cfg_we = 1'b0;
  endtask
  task automatic go(input logic [1:0] s);
    start = s;
    tick;
    start = 2'b00;
  endtask
  task automatic halt(input logic [1:0] s);
    stop = s;
    tick;
    stop = 2'b00;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++;
    if ({pulse_out, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_init got=%b exp=000000", {pulse_out, busy, done});
    end
    rst = 1'b0;
    cfg(1'b0, 2'd1, 10, 3, 0);
    go(2'b01);
    repeat (2) tick;
    checks++;
    if (pulse_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre pulse=%b exp=1", pulse_out[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pulse_out, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=000000", {pulse_out, busy, done});
    end
    repeat (2) tick;
    checks++;
    if ({pulse_out, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=000000", {pulse_out, busy, done});
    end
    rst = 1'b0;
    go(2'b01);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_cfg_off busy=%b exp=0", busy[0]);
    end
  endtask
  task automatic test_periodic;
    cfg(1'b0, 2'd1, 10, 3, 0);
    go(2'b01);
    checks++;
    if (busy[0] !== 1'b1 || pulse_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL periodic_start busy=%b pulse=%b exp busy=1 pulse=0", busy[0], pulse_out[0]);
    end
    for (int n = 1; n <= 50; n++) begin
      logic e;
      tick;
      e = ((n - 1) % 10) < 3;
      checks++;
      if (pulse_out[0] !== e || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL periodic n=%0d pulse=%b done=%b exp pulse=%b done=0", n, pulse_out[0], done[0], e);
      end
    end
    halt(2'b01);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL periodic_stop busy=%b exp=0", busy[0]);
    end
  endtask
  task automatic test_oneshot;
    cfg(1'b0, 2'd2, 10, 4, 0);
    for (int r = 0; r < 2; r++) begin
      go(2'b01);
      for (int n = 1; n <= 6; n++) begin
        logic ep, ed, eb;
        start = (n == 2) ? 2'b01 : 2'b00;
        tick;
        start = 2'b00;
        ep = n <= 4;
        ed = n == 5;
        eb = n <= 4;
        checks++;
        if (pulse_out[0] !== ep || done[0] !== ed || busy[0] !== eb) begin
          errors++;
          $display("FAIL oneshot r=%0d n=%0d pulse=%b done=%b busy=%b exp %b %b %b",
                   r, n, pulse_out[0], done[0], busy[0], ep, ed, eb);
        end
      end
    end
  endtask
  task automatic test_burst;
    cfg(1'b0, 2'd3, 6, 2, 3);
    go(2'b01);
    for (int n = 1; n <= 17; n++) begin
      logic ep, ed, eb;
      tick;
      ep = n == 1 || n == 2 || n == 7 || n == 8 || n == 13 || n == 14;
      ed = n == 15;
      eb = n <= 14;
      checks++;
      if (pulse_out[0] !== ep || done[0] !== ed || busy[0] !== eb) begin
        errors++;
        $display("FAIL burst n=%0d pulse=%b done=%b busy=%b exp %b %b %b",
                 n, pulse_out[0], done[0], busy[0], ep, ed, eb);
      end
    end
    cfg(1'b0, 2'd3, 6, 2, 0);
    go(2'b01);
    for (int n = 1; n <= 8; n++) begin
      logic ep, ed;
      tick;
      ep = n <= 2;
      ed = n == 3;
      checks++;
      if (pulse_out[0] !== ep || done[0] !== ed) begin
        errors++;
        $display("FAIL burst_cnt0 n=%0d pulse=%b done=%b exp %b %b", n, pulse_out[0], done[0], ep, ed);
      end
    end
  endtask
  task automatic test_clamp;
    cfg(1'b0, 2'd1, 1, 0, 0);
    go(2'b01);
    for (int n = 1; n <= 6; n++) begin
      tick;
      checks++;
      if (pulse_out[0] !== n[0]) begin
        errors++;
        $display("FAIL clamp_p1w0 n=%0d pulse=%b exp=%b", n, pulse_out[0], n[0]);
      end
    end
    halt(2'b01);
    cfg(1'b0, 2'd1, 5, 9, 0);
    go(2'b01);
    for (int n = 1; n <= 10; n++) begin
      logic e;
      tick;
      e = ((n - 1) % 5) < 4;
      checks++;
      if (pulse_out[0] !== e) begin
        errors++;
        $display("FAIL clamp_p5w9 n=%0d pulse=%b exp=%b", n, pulse_out[0], e);
      end
    end
    halt(2'b01);
    cfg(1'b0, 2'd1, 10, 3, 0);
    go(2'b01);
    for (int n = 1; n <= 22; n++) begin
      logic e;
      if (n == 2) begin
        cfg_period = 16'd4;
        cfg_we = 1'b1;
      end
      tick;
      cfg_we = 1'b0;
      e = (n <= 10) ? (n <= 3) : (((n - 11) % 4) < 3);
      checks++;
      if (pulse_out[0] !== e) begin
        errors++;
        $display("FAIL cfg_midpulse n=%0d pulse=%b exp=%b", n, pulse_out[0], e);
      end
    end
    halt(2'b01);
  endtask
  task automatic test_stop;
    cfg(1'b0, 2'd2, 10, 5, 0);
    go(2'b01);
    tick;
    halt(2'b01);
    checks++;
    if (pulse_out[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL stop_high pulse=%b busy=%b exp 0 0", pulse_out[0], busy[0]);
    end
    for (int n = 0; n < 3; n++) begin
      tick;
      checks++;
      if (done[0] !== 1'b0) begin
        errors++;
        $display("FAIL stop_nodone n=%0d done=%b exp=0", n, done[0]);
      end
    end
    start = 2'b01;
    stop = 2'b01;
    tick;
    start = 2'b00;
    stop = 2'b00;
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_stop busy=%b exp=0", busy[0]);
    end
    tick;
    checks++;
    if (pulse_out[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_idle pulse=%b busy=%b exp 0 0", pulse_out[0], busy[0]);
    end
  endtask
  task automatic test_channels;
    cfg(1'b0, 2'd1, 10, 3, 0);
    cfg(1'b1, 2'd2, 6, 2, 0);
    go(2'b01);
    repeat (2) tick;
    go(2'b10);
    checks++;
    if (busy !== 2'b11) begin
      errors++;
      $display("FAIL chan_busy busy=%b exp=11", busy);
    end
    for (int m = 1; m <= 5; m++) begin
      logic e0, e1, d1;
      tick;
      e0 = ((m + 2) % 10) < 3;
      e1 = m <= 2;
      d1 = m == 3;
      checks++;
      if (pulse_out[0] !== e0 || pulse_out[1] !== e1 || done[1] !== d1 || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL chan_indep m=%0d pulse=%b done=%b exp pulse=%b%b done=%b0",
                 m, pulse_out, done, e1, e0, d1);
      end
    end
    halt(2'b11);
    checks++;
    if (busy !== 2'b00) begin
      errors++;
      $display("FAIL chan_stop busy=%b exp=00", busy);
    end
  endtask
  initial begin
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_ch = 1'b0;
    cfg_mode = 2'd0;
    cfg_period = 16'd2;
    cfg_width = 8'd1;
    cfg_count = 8'd1;
    start = 2'b00;
    stop = 2'b00;
    test_reset;
    test_periodic;
    test_oneshot;
    test_burst;
    test_clamp;
    test_stop;
    test_channels;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
